// File: rtl/mem_pkg.sv
// Shared definitions for the 16-bit single-port memory interface.
// The memory model and the EDSAC core both use this package.
package mem_pkg;

    localparam int WORD_W        = 16;
    localparam int ABITS_DEFAULT = 9;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_master.sv
// Initiator side of the single-port memory interface: serves core read/write requests
// one at a time and sweeps the whole memory to zero after reset or on command.
module mem_master
    import mem_pkg::*;
#(
    parameter int ABITS          = ABITS_DEFAULT,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ABITS-1:0]  req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    input  logic              clear,
    output logic              busy,
    output logic [ABITS-1:0]  mem_addr,
    output logic [WORD_W-1:0] mem_d,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [WORD_W-1:0] mem_q,
    input  logic              mem_wait
);

    state_t              state, state_nx;
    logic [ABITS-1:0]    clr_cnt;
    logic [ABITS-1:0]    addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                we_q;
    logic                accept;

    assign accept = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            // Wraps to zero on the final accepted write, ready for the next sweep.
            if (state == CLEAR && !mem_wait) begin
                clr_cnt <= clr_cnt + ABITS'(1);
            end
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR: if (!mem_wait && clr_cnt == '1) state_nx = IDLE;
            IDLE: begin
                if (clear)          state_nx = CLEAR;
                else if (req_valid) state_nx = ACC;
            end
            ACC:     if (!mem_wait) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_d     = wdata_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                mem_addr = clr_cnt;
                mem_d    = '0;
                mem_wr   = 1'b1;
                busy     = 1'b1;
            end
            IDLE: req_ready = !clear;
            ACC: begin
                mem_rd = !we_q;
                mem_wr = we_q;
            end
            // Strobes stay low here; this gap re-arms the memory's delay counter.
            DONE: begin
                rsp_valid = 1'b1;
                if (!we_q) rsp_rdata = mem_q;
            end
            default: ;
        endcase
        if (rst) begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = '0;
            busy      = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: memory model with programmable wait, response scoreboard.
module tb_mem_master;
    import mem_pkg::*;

    localparam int ABITS = ABITS_DEFAULT;
    localparam int DEPTH = 1 << ABITS;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ABITS-1:0]  req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              clear, busy;
    logic [ABITS-1:0]  mem_addr;
    logic [WORD_W-1:0] mem_d;
    logic              mem_rd, mem_wr;
    logic [WORD_W-1:0] mem_q = '0;
    logic              mem_wait;

    mem_master #(.ABITS(ABITS), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .clear(clear), .busy(busy),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_q(mem_q), .mem_wait(mem_wait)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_cnt = 0;
    int rsp_edge = 0;
    int dly = 0;
    int wcnt = 0;
    int rd_hi = 0, rd_bad_addr = 0, strobe_in_done = 0;
    logic [ABITS-1:0]  trk_addr = '0;
    logic [WORD_W-1:0] exp_q [$];
    logic [WORD_W-1:0] mem_arr [DEPTH];
    logic [WORD_W-1:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: wait stays high for dly cycles after a strobe rises.
    assign mem_wait = (mem_rd || mem_wr) && (wcnt < dly);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd || mem_wr) begin
            if (mem_wait) wcnt <= wcnt + 1;
            else begin
                if (mem_wr) mem_arr[mem_addr] <= mem_d;
                if (mem_rd) mem_q <= mem_arr[mem_addr];
            end
        end else begin
            wcnt <= 0;
        end
    end

    // Response scoreboard and strobe monitor.
    always @(negedge clk) begin
        if (mem_rd) begin
            rd_hi++;
            if (mem_addr != trk_addr) rd_bad_addr++;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_edge = cyc;
            if (mem_rd || mem_wr) strobe_in_done++;
            check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic do_req(input logic we, input logic [ABITS-1:0] addr, input logic [WORD_W-1:0] wdata,
                          input bit push, input bit keep, output int acc_edge);
        bit ok = 1'b0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        if (push) exp_q.push_back(we ? 16'h0000 : ref_mem[addr]);
        if (we) ref_mem[addr] = wdata;
        acc_edge = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; acc_edge = cyc + 1; break; end
        end
        check("accept_in_time", 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_in_time", 32'(rsp_cnt >= target), 32'd1);
    endtask

    task automatic wait_sweep_done();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_finishes", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int errs;
        int a, r0, t0;
        int acc [4];
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Power-on sweep: one write per cycle at 0..DEPTH-1
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!(mem_wr && !mem_rd && mem_addr == ABITS'(i) && mem_d == 16'h0 && busy)) errs++;
        end
        check("sweep_beats_bad", 32'(errs), 32'd0);
        @(negedge clk);
        check("sweep_end_busy", 32'(busy), 32'd0);
        check("sweep_end_ready", 32'(req_ready), 32'd1);
        check("sweep_end_wr", 32'(mem_wr), 32'd0);
        @(posedge clk); #1;

        // Write then read, no wait states
        do_req(1'b1, ABITS'(5), 16'h1234, 1'b1, 1'b0, a);
        wait_rsp(1);
        check("wr_latency", 32'(rsp_edge - a), 32'd1);
        do_req(1'b0, ABITS'(5), 16'h0000, 1'b1, 1'b0, a);
        wait_rsp(2);
        check("rd_latency", 32'(rsp_edge - a), 32'd1);

        // Read with three wait cycles
        dly = 3; rd_hi = 0; rd_bad_addr = 0; strobe_in_done = 0; trk_addr = ABITS'(5);
        do_req(1'b0, ABITS'(5), 16'h0000, 1'b1, 1'b0, a);
        wait_rsp(3);
        check("wait_latency", 32'(rsp_edge - a), 32'd4);
        check("wait_rd_cycles", 32'(rd_hi), 32'd4);
        check("wait_addr_stable", 32'(rd_bad_addr), 32'd0);
        check("wait_strobe_in_done", 32'(strobe_in_done), 32'd0);
        dly = 0;

        // clear takes priority over a pending request
        clear = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = ABITS'(5);
        @(negedge clk);
        check("clear_blocks_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        t0 = cyc;
        check("clear_busy", 32'(busy), 32'd1);
        check("clear_sweep_start", 32'(mem_addr), 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        do_req(1'b0, ABITS'(5), 16'h0000, 1'b1, 1'b0, a);
        check("accept_after_sweep", 32'(a - t0), 32'(DEPTH + 1));
        wait_rsp(4);

        // Reset during a stalled read: no response, sweep restarts at 0
        dly = 5;
        do_req(1'b0, ABITS'(5), 16'h0000, 1'b0, 1'b0, a);
        rst = 1'b1;
        r0 = rsp_cnt;
        @(negedge clk);
        check("rst_acc_rd", 32'(mem_rd), 32'd0);
        check("rst_acc_wr", 32'(mem_wr), 32'd0);
        check("rst_acc_busy", 32'(busy), 32'd1);
        check("rst_acc_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        dly = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_sweep_wr", 32'(mem_wr), 32'd1);
        check("rst_sweep_addr", 32'(mem_addr), 32'd0);
        wait_sweep_done();
        check("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);

        // Back-to-back reads with req_valid held high
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, ABITS'(16 + i), 16'hC000 + 16'(i * 17), 1'b1, 1'b0, a);
            wait_rsp(r0 + i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, ABITS'(16 + i), 16'h0000, 1'b1, (i != 3), acc[i]);
        end
        wait_rsp(r0 + 8);
        for (int i = 1; i < 4; i++) check("b2b_interval", 32'(acc[i] - acc[i-1]), 32'd3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
